// File: rtl/fft_stream_pkg.sv
`default_nettype none
// ============================================================================
// fft_stream_pkg : shared constants, sample type and helpers for the FFT output stream
// Rev 1.0
// ============================================================================
package fft_stream_pkg;

   localparam int DW    = 16;
   localparam int N     = 8;
   localparam int LOG2N = 3;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } out_state_e;

   // Radix-2 DIT/DIF natural <-> bit-reversed index mapping for 8 points.
   function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] b);
      return {b[0], b[1], b[2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_serializer_if.sv
`default_nettype none
// ============================================================================
// fft_out_serializer_if : valid/ready complex-sample stream from serializer to consumer
// Rev 1.0
// ============================================================================
interface fft_out_serializer_if #(
   parameter int DW = 16
) ();

   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_re;
   logic [DW-1:0] m_im;
   logic [2:0]    m_idx;
   logic          m_last;

   modport master (
      output m_valid,
      output m_re,
      output m_im,
      output m_idx,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_re,
      input  m_im,
      input  m_idx,
      input  m_last,
      output m_ready
   );

endinterface
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// fft_frame_bank : one frame of N complex words, parallel write-all, indexed read, full flag
// Rev 1.0
// ============================================================================
module fft_frame_bank
   import fft_stream_pkg::LOG2N;
#(
   parameter int DW = 16,
   parameter int N  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [N*DW-1:0]   wr_re,
   input  logic [N*DW-1:0]   wr_im,
   input  logic              clr,
   input  logic [LOG2N-1:0]  rd_idx,
   output logic [DW-1:0]     rd_re,
   output logic [DW-1:0]     rd_im,
   output logic              full
);

   logic [DW-1:0] r_re [N];
   logic [DW-1:0] r_im [N];
   logic          r_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            r_re[i] <= '0;
            r_im[i] <= '0;
         end
         r_full <= 1'b0;
      end else begin
         if (wr_en) begin
            for (int i = 0; i < N; i++) begin
               r_re[i] <= wr_re[i*DW +: DW];
               r_im[i] <= wr_im[i*DW +: DW];
            end
         end
         // A bank is only written while empty and only cleared while full,
         // so set and clear never collide; set is given priority regardless.
         if (wr_en) begin
            r_full <= 1'b1;
         end else if (clr) begin
            r_full <= 1'b0;
         end
      end
   end

   assign rd_re = r_re[rd_idx];
   assign rd_im = r_im[rd_idx];
   assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/fft_out_serializer.sv
`default_nettype none
// ============================================================================
// fft_out_serializer : ping-pong capture of parallel FFT frames, streamed one sample per beat
// Rev 1.0
// ============================================================================
module fft_out_serializer
   import fft_stream_pkg::LOG2N;
   import fft_stream_pkg::bitrev3;
#(
   parameter int DW     = 16,
   parameter int N      = 8,
   parameter int BITREV = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cap_valid,
   input  logic [N*DW-1:0]      y_re,
   input  logic [N*DW-1:0]      y_im,
   output logic                 cap_ready,
   fft_out_serializer_if.master m_if,
   output logic                 ovf,
   input  logic                 ovf_clr
);

   localparam logic [0:0]       c_st_idle   = fft_stream_pkg::IDLE;
   localparam logic [0:0]       c_st_stream = fft_stream_pkg::STREAM;
   localparam logic [LOG2N-1:0] c_last_beat = LOG2N'(N - 1);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [LOG2N-1:0] r_beat;
   logic             r_ovf;

   logic [1:0]       w_full;
   logic [1:0]       w_wr_en;
   logic [1:0]       w_clr;
   logic [DW-1:0]    w_bank_re [2];
   logic [DW-1:0]    w_bank_im [2];

   logic [LOG2N-1:0] w_ord;
   logic             w_wr_full;
   logic             w_cap;
   logic             w_drop;
   logic             w_valid;
   logic             w_hs;
   logic             w_last_hs;
   logic             w_next_avail;
   logic [DW-1:0]    w_rd_re;
   logic [DW-1:0]    w_rd_im;

   // ------------------------------------------------------------------
   // Ping-pong storage
   // ------------------------------------------------------------------
   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank #(
         .DW (DW),
         .N  (N)
      ) u_bank (
         .clk    (clk),
         .reset  (reset),
         .wr_en  (w_wr_en[b]),
         .wr_re  (y_re),
         .wr_im  (y_im),
         .clr    (w_clr[b]),
         .rd_idx (w_ord),
         .rd_re  (w_bank_re[b]),
         .rd_im  (w_bank_im[b]),
         .full   (w_full[b])
      );
   end

   if (BITREV != 0) begin : g_ord_rev
      assign w_ord = bitrev3(r_beat);
   end else begin : g_ord_nat
      assign w_ord = r_beat;
   end

   // The write bank can only be full when both are, so this is the drop test.
   // Full flags are registered: a bank released on this edge is not yet free.
   assign w_wr_full = w_full[r_wr_sel];
   assign w_cap     = cap_valid & ~w_wr_full;
   assign w_drop    = cap_valid & w_wr_full;

   assign w_valid   = (r_state == c_st_stream);
   assign w_hs      = w_valid & m_if.m_ready;
   assign w_last_hs = w_hs & (r_beat == c_last_beat);

   assign w_wr_en   = {w_cap & r_wr_sel, w_cap & ~r_wr_sel};
   assign w_clr     = {w_last_hs & r_rd_sel, w_last_hs & ~r_rd_sel};

   // While streaming, any capture necessarily lands in the other bank.
   assign w_next_avail = w_full[~r_rd_sel] | w_cap;

   // ------------------------------------------------------------------
   // Output FSM
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_full[r_rd_sel] | w_cap) begin
               w_state_nxt = c_st_stream;
            end
         end
         c_st_stream: begin
            if (w_last_hs & ~w_next_avail) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= c_st_idle;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_beat   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap) begin
            r_wr_sel <= ~r_wr_sel;
         end
         if (w_last_hs) begin
            r_rd_sel <= ~r_rd_sel;
         end
         if (w_hs) begin
            r_beat <= r_beat + LOG2N'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output muxing; data is forced to zero whenever no beat is offered
   // ------------------------------------------------------------------
   assign w_rd_re = w_bank_re[r_rd_sel];
   assign w_rd_im = w_bank_im[r_rd_sel];

   assign m_if.m_valid = w_valid;
   assign m_if.m_re    = w_valid ? w_rd_re : '0;
   assign m_if.m_im    = w_valid ? w_rd_im : '0;
   assign m_if.m_idx   = w_valid ? w_ord : '0;
   assign m_if.m_last  = w_valid & (r_beat == c_last_beat);

   // Derived purely from the bank full flops, so it never glitches.
   assign cap_ready = ~(&w_full);
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// ============================================================================
// tb_fft_out_serializer : randomized bench with a frame-queue reference model
// Rev 1.0
// ============================================================================
module tb_fft_out_serializer;

   localparam int DW = 16;
   localparam int N  = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            cap_valid;
   logic [N*DW-1:0] y_re;
   logic [N*DW-1:0] y_im;
   logic            ovf_clr;
   logic            cap_ready0, cap_ready1, ovf0, ovf1;

   always #5 clk = ~clk;

   fft_out_serializer_if #(.DW(DW)) if0 ();
   fft_out_serializer_if #(.DW(DW)) if1 ();

   fft_out_serializer #(.DW(DW), .N(N), .BITREV(0)) dut0 (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .y_re(y_re), .y_im(y_im),
      .cap_ready(cap_ready0), .m_if(if0), .ovf(ovf0), .ovf_clr(ovf_clr)
   );

   fft_out_serializer #(.DW(DW), .N(N), .BITREV(1)) dut1 (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .y_re(y_re), .y_im(y_im),
      .cap_ready(cap_ready1), .m_if(if1), .ovf(ovf1), .ovf_clr(ovf_clr)
   );

   int            checks = 0;
   int            errors = 0;
   bit            sel;          // 0: observe natural-order DUT, 1: bit-reversed DUT
   logic [DW-1:0] fr_re [N];
   logic [DW-1:0] fr_im [N];

   // Reference model: FIFO of every sample still owed to the consumer.
   logic [DW-1:0] q_re [$];
   logic [DW-1:0] q_im [$];
   int            q_idx [$];
   bit            m_ovf;

   logic          o_valid, o_last, o_cr, o_ovf, e_valid, e_last, e_cr, e_ovf;
   logic [DW-1:0] o_re, o_im, e_re, e_im;
   logic [2:0]    o_idx, e_idx;

   function automatic int rev3(input int k);
      return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
   endfunction

   task automatic rand_frame();
      for (int k = 0; k < N; k++) begin
         fr_re[k] = DW'($urandom);
         fr_im[k] = DW'($urandom);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      cap_valid = 1'b0;
      ovf_clr   = 1'b0;
      m_ovf     = 1'b0;
      q_re.delete();
      q_im.delete();
      q_idx.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock: drive inputs, sample outputs mid-cycle, form expectations, advance model.
   task automatic cycle(input bit cv, input bit rdy, input bit clr);
      bit drop;
      @(posedge clk);
      #1;
      cap_valid = cv;
      ovf_clr   = clr;
      for (int k = 0; k < N; k++) begin
         y_re[k*DW +: DW] = fr_re[k];
         y_im[k*DW +: DW] = fr_im[k];
      end
      if0.m_ready = sel ? 1'b1 : rdy;
      if1.m_ready = sel ? rdy : 1'b1;
      @(negedge clk);
      o_valid = sel ? if1.m_valid : if0.m_valid;
      o_last  = sel ? if1.m_last  : if0.m_last;
      o_idx   = sel ? if1.m_idx   : if0.m_idx;
      o_re    = sel ? if1.m_re    : if0.m_re;
      o_im    = sel ? if1.m_im    : if0.m_im;
      o_cr    = sel ? cap_ready1  : cap_ready0;
      o_ovf   = sel ? ovf1        : ovf0;
      e_valid = (q_re.size() != 0);
      e_re    = e_valid ? q_re[0] : '0;
      e_im    = e_valid ? q_im[0] : '0;
      e_idx   = e_valid ? 3'(q_idx[0]) : 3'd0;
      e_last  = e_valid && (q_re.size() % 8 == 1);
      e_cr    = (q_re.size() <= 8);
      e_ovf   = m_ovf;
      drop    = cv && (q_re.size() > 8);
      if (e_valid && rdy) begin
         void'(q_re.pop_front());
         void'(q_im.pop_front());
         void'(q_idx.pop_front());
      end
      if (cv && !drop) begin
         for (int b = 0; b < N; b++) begin
            int k;
            k = sel ? rev3(b) : b;
            q_re.push_back(fr_re[k]);
            q_im.push_back(fr_im[k]);
            q_idx.push_back(k);
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({if0.m_valid, if0.m_last, if0.m_idx, if0.m_re, if0.m_im, ovf0, cap_ready0} !==
          {1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got v%b l%b i%0d re%h im%h ov%b cr%b, want all zero with cr=1",
                  if0.m_valid, if0.m_last, if0.m_idx, if0.m_re, if0.m_im, ovf0, cap_ready0);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single_frame();
      int beats = 0;
      sel = 1'b0;
      do_reset();
      for (int k = 0; k < N; k++) begin
         fr_re[k] = DW'(k * 100);
         fr_im[k] = DW'(-k);
      end
      for (int c = 0; c < 12; c++) begin
         cycle(c == 0, 1'b1, 1'b0);
         if (o_valid) beats++;
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL single_frame c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
      checks++;
      if (beats != 8) begin
         errors++;
         $display("FAIL single_frame_beats: got %0d, want 8", beats);
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      do_reset();
      rand_frame();
      for (int c = 0; c < 30; c++) begin
         cycle(c == 0, c[0], 1'b0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL backpressure c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
   endtask

   task automatic test_overflow();
      sel = 1'b0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         bit cv, rdy, clr;
         if (c < 3) rand_frame();
         cv  = (c < 3) || (c == 27) || (c == 28) || (c == 29);
         rdy = (c >= 4) && (c < 26);
         clr = (c == 24) || (c == 29);
         cycle(cv, rdy, clr);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL overflow c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
         if (c == 4) begin
            checks++;
            if ({o_ovf, o_cr} !== 2'b10) begin
               errors++;
               $display("FAIL overflow_flags: got ovf=%b cap_ready=%b, want ovf=1 cap_ready=0", o_ovf, o_cr);
            end
         end
         if (c == 26) begin
            checks++;
            if (o_ovf !== 1'b0) begin
               errors++;
               $display("FAIL overflow_clear: got ovf=%b, want 0", o_ovf);
            end
         end
         if (c == 31) begin
            checks++;
            if (o_ovf !== 1'b1) begin
               errors++;
               $display("FAIL overflow_set_wins: got ovf=%b, want 1", o_ovf);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit fired = 1'b0;
      bit chk   = 1'b0;
      int hs    = 0;
      sel = 1'b0;
      do_reset();
      rand_frame();
      for (int c = 0; c < 24; c++) begin
         bit cv;
         cv = (c == 0) || (!fired && q_re.size() == 1);
         if (cv && c != 0) begin
            rand_frame();
            fired = 1'b1;
         end
         cycle(cv, 1'b1, 1'b0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL back_to_back c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
         if (chk) begin
            checks++;
            if ({o_valid, o_idx, o_re} !== {1'b1, 3'd0, fr_re[0]}) begin
               errors++;
               $display("FAIL back_to_back_nogap: got v%b i%0d re%h, want v1 i0 re%h", o_valid, o_idx, o_re, fr_re[0]);
            end
            chk = 1'b0;
         end
         if (cv && c != 0) chk = 1'b1;
      end
      // Capture colliding with the release of a full bank is dropped.
      do_reset();
      for (int c = 0; c < 30; c++) begin
         bit cv, rdy;
         rdy = (c >= 2);
         cv  = (c < 2) || (rdy && q_re.size() == 9);
         if (cv) rand_frame();
         cycle(cv, rdy, 1'b0);
         if (o_valid && rdy) hs++;
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL release_drop c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
      checks++;
      if (hs != 16 || o_ovf !== 1'b1) begin
         errors++;
         $display("FAIL release_drop_total: got beats=%0d ovf=%b, want beats=16 ovf=1", hs, o_ovf);
      end
   endtask

   task automatic test_bitrev();
      int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      int n = 0;
      sel = 1'b1;
      do_reset();
      rand_frame();
      for (int c = 0; c < 12; c++) begin
         cycle(c == 0, 1'b1, 1'b0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL bitrev c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
         if (o_valid && n < 8) begin
            checks++;
            if (int'(o_idx) != seq[n] || o_re !== fr_re[seq[n]]) begin
               errors++;
               $display("FAIL bitrev_order beat%0d: got idx=%0d re=%h, want idx=%0d re=%h",
                        n, o_idx, o_re, seq[n], fr_re[seq[n]]);
            end
            n++;
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_mid_reset();
      sel = 1'b0;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         rand_frame();
         cycle(c < 3, (c >= 3) && (c < 6), 1'b0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL mid_reset_pre c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({if0.m_valid, if0.m_last, if0.m_idx, if0.m_re, if0.m_im, ovf0, cap_ready0} !==
          {1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_immediate: got v%b l%b i%0d re%h im%h ov%b cr%b, want all zero with cr=1",
                  if0.m_valid, if0.m_last, if0.m_idx, if0.m_re, if0.m_im, ovf0, cap_ready0);
      end
      do_reset();
      rand_frame();
      for (int c = 0; c < 12; c++) begin
         cycle(c == 0, 1'b1, 1'b0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL mid_reset_post c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
   endtask

   task automatic test_random();
      sel = 1'b0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(3) == 0) rand_frame();
         cycle($urandom_range(2) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0);
         checks++;
         if ({o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf} !== {e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf}) begin
            errors++;
            $display("FAIL random c%0d: got v%b l%b i%0d re%h im%h cr%b ov%b, want v%b l%b i%0d re%h im%h cr%b ov%b",
                     c, o_valid, o_last, o_idx, o_re, o_im, o_cr, o_ovf, e_valid, e_last, e_idx, e_re, e_im, e_cr, e_ovf);
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      cap_valid   = 1'b0;
      ovf_clr     = 1'b0;
      y_re        = '0;
      y_im        = '0;
      if0.m_ready = 1'b0;
      if1.m_ready = 1'b0;
      sel         = 1'b0;
      m_ovf       = 1'b0;
      for (int k = 0; k < N; k++) begin
         fr_re[k] = '0;
         fr_im[k] = '0;
      end
      test_reset();
      test_single_frame();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_bitrev();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
